// File: rtl/pipe_stage_reg.sv
// Parametrised lc3b inter-stage register: valid/ready handshake, flush bubble, saturating stall counter.
// Define PIPE_SKID_EN to add a skid entry so in_ready depends on registered state only.
module pipe_stage_reg #(
    parameter int PAYLOAD_W   = 128,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [PAYLOAD_W-1:0]   in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [PAYLOAD_W-1:0]   out_data,
    output logic [STALL_CNT_W-1:0] stall_cnt
);
    localparam logic [STALL_CNT_W-1:0] CNT_ONE = 1;

    logic                   out_valid_q, out_valid_d;
    logic [PAYLOAD_W-1:0]   out_data_q, out_data_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic                   in_fire, out_fire;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid_q & out_ready;

    // Flush does not clear the counter; a stalled flush cycle still counts.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid_q && !out_ready && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
    end

`ifdef PIPE_SKID_EN
    logic                 skid_valid_q, skid_valid_d;
    logic [PAYLOAD_W-1:0] skid_data_q, skid_data_d;

    assign in_ready = ~reset & ~flush & ~skid_valid_q;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            out_data_d   = '0;
            skid_valid_d = 1'b0;
            skid_data_d  = '0;
        end else if (!out_valid_q || out_fire) begin
            // Skid is older than anything upstream, so it drains first.
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                skid_valid_d = 1'b0;
            end else if (in_fire) begin
                out_valid_d = 1'b1;
                out_data_d  = in_data;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (in_fire) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
        end else begin
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end
`else
    assign in_ready = ~reset & ~flush & (~out_valid_q | out_ready);

    // NOTE: every signal driven here gets a default first so no path infers a latch.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (flush) begin
            out_valid_d = 1'b0;
            out_data_d  = '0;
        end else if (in_fire) begin
            out_valid_d = 1'b1;
            out_data_d  = in_data;
        end else if (out_fire) begin
            out_valid_d = 1'b0;
        end
    end
`endif

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    // NOTE: the payload registers are reset too, because an all-zero payload is the NOP bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg; dut_s uses a 4-bit stall counter for saturation.
module tb_pipe_stage_reg;
    localparam int PW = 128;

    logic          clk = 1'b0;
    logic          reset, flush;
    logic          in_valid, in_ready, out_valid, out_ready;
    logic [PW-1:0] in_data, out_data;
    logic [15:0]   stall_cnt;

    logic          s_in_valid, s_in_ready, s_out_valid, s_out_ready;
    logic [7:0]    s_in_data, s_out_data;
    logic [3:0]    s_stall_cnt;

    int checks = 0;
    int errors = 0;

    pipe_stage_reg #(.PAYLOAD_W(PW), .STALL_CNT_W(16)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .stall_cnt(stall_cnt)
    );

    pipe_stage_reg #(.PAYLOAD_W(8), .STALL_CNT_W(4)) dut_s (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
        .stall_cnt(s_stall_cnt)
    );

    always #5 clk = ~clk;

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0;
        in_valid = 1'b1; in_data = {PW{1'b1}}; out_ready = 1'b1;
        s_in_valid = 1'b0; s_in_data = 8'h00; s_out_ready = 1'b1;
        tick(); tick();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b exp 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL rst_out_data got %h exp 0", out_data); end
        checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL rst_stall_cnt got %0d exp 0", stall_cnt); end
        reset = 1'b0; in_valid = 1'b0;
        tick();
    endtask

    task automatic test_single();
        logic [PW-1:0] exp_data;
        exp_data = {8{16'hA5A5}};
        in_valid = 1'b1; in_data = exp_data; out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL single_in_ready got %b exp 1", in_ready); end
        tick();
        in_valid = 1'b0; in_data = '0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_out_valid got %b exp 1", out_valid); end
        checks++; if (out_data !== exp_data) begin errors++; $display("FAIL single_out_data got %h exp %h", out_data, exp_data); end
        checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL single_stall_cnt got %0d exp 0", stall_cnt); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_out_valid got %b exp 0", out_valid); end
        checks++; if (out_data !== exp_data) begin errors++; $display("FAIL drain_hold_data got %h exp %h", out_data, exp_data); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1; in_data = PW'(i);
            #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready[%0d] got %b exp 1", i, in_ready); end
            tick();
            checks++; if (out_valid !== 1'b1 || out_data !== PW'(i)) begin
                errors++; $display("FAIL b2b_out[%0d] got v=%b d=%h exp v=1 d=%0d", i, out_valid, out_data, i);
            end
        end
        in_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_end_valid got %b exp 0", out_valid); end
    endtask

    task automatic test_stall();
        logic exp_second_accept;
`ifdef PIPE_SKID_EN
        exp_second_accept = 1'b1;
`else
        exp_second_accept = 1'b0;
`endif
        in_valid = 1'b1; in_data = PW'(8'h11); out_ready = 1'b0;
        tick();
        in_data = PW'(8'h22);
        #1;
        checks++; if (in_ready !== exp_second_accept) begin
            errors++; $display("FAIL stall_second_ready got %b exp %b", in_ready, exp_second_accept);
        end
        for (int i = 1; i <= 5; i++) begin
            tick();
            checks++; if (out_valid !== 1'b1 || out_data !== PW'(8'h11)) begin
                errors++; $display("FAIL stall_hold[%0d] got v=%b d=%h exp v=1 d=11", i, out_valid, out_data);
            end
        end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_full_ready got %b exp 0", in_ready); end
        checks++; if (stall_cnt !== 16'd5) begin errors++; $display("FAIL stall_cnt5 got %0d exp 5", stall_cnt); end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_data !== PW'(8'h22)) begin
            errors++; $display("FAIL stall_release got v=%b d=%h exp v=1 d=22", out_valid, out_data);
        end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_no_dup got %b exp 0", out_valid); end
        checks++; if (stall_cnt !== 16'd5) begin errors++; $display("FAIL stall_cnt_keep got %0d exp 5", stall_cnt); end
    endtask

    task automatic test_saturate();
        s_in_valid = 1'b1; s_in_data = 8'h5A; s_out_ready = 1'b0;
        tick();
        s_in_valid = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 10) begin
                checks++; if (s_stall_cnt !== 4'd10) begin errors++; $display("FAIL sat_mid got %0d exp 10", s_stall_cnt); end
            end
        end
        checks++; if (s_stall_cnt !== 4'd15) begin errors++; $display("FAIL sat_cap got %0d exp 15", s_stall_cnt); end
        checks++; if (s_out_data !== 8'h5A) begin errors++; $display("FAIL sat_data got %h exp 5a", s_out_data); end
        s_out_ready = 1'b1;
        tick();
        checks++; if (s_out_valid !== 1'b0 || s_stall_cnt !== 4'd15) begin
            errors++; $display("FAIL sat_release got v=%b cnt=%0d exp v=0 cnt=15", s_out_valid, s_stall_cnt);
        end
    endtask

    task automatic test_flush();
        in_valid = 1'b1; in_data = PW'(8'h33); out_ready = 1'b0;
        tick();
        in_data = PW'(8'h44);
        tick();
        flush = 1'b1; in_data = PW'(8'h55);
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got %b exp 0", in_ready); end
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        checks++; if (out_valid !== 1'b0 || out_data !== '0) begin
            errors++; $display("FAIL flush_bubble got v=%b d=%h exp v=0 d=0", out_valid, out_data);
        end
        checks++; if (stall_cnt !== 16'd7) begin errors++; $display("FAIL flush_stall_cnt got %0d exp 7", stall_cnt); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_no_leak got %b exp 0", out_valid); end
    endtask

    task automatic test_reset_midstream();
        in_valid = 1'b1; in_data = PW'(8'h66); out_ready = 1'b1;
        tick();
        in_data = PW'(8'h77); out_ready = 1'b0;
        tick();
        reset = 1'b1; in_data = PW'(8'h88);
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready got %b exp 0", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b0 || out_data !== '0 || stall_cnt !== 16'd0) begin
            errors++; $display("FAIL mid_rst_state got v=%b d=%h cnt=%0d exp all 0", out_valid, out_data, stall_cnt);
        end
        reset = 1'b0; in_data = PW'(8'h99); out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_data !== PW'(8'h99)) begin
            errors++; $display("FAIL mid_rst_first got v=%b d=%h exp v=1 d=99", out_valid, out_data);
        end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_no_stale got %b exp 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_saturate();
        test_flush();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic, parametrised inter-stage pipeline register for the lc3b pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Replaces per-stage hand-written latches with one block that carries an opaque packed payload.
- Adds a valid/ready handshake, a flush that inserts a bubble, and a saturating stall-cycle counter.
- An optional skid entry breaks the combinational ready path between stages.

Parameters:
- PAYLOAD_W, 128: width of the packed payload (control word, PC, instruction, operands, immediates, register ids).
- STALL_CNT_W, 16: width of the stall-cycle counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  synchronous kill of all held entries (branch mispredict or trap).
- in_valid  input  1  upstream stage presents a payload.
- in_ready  output  1  block can accept a payload this cycle.
- in_data  input  PAYLOAD_W  upstream payload.
- out_valid  output  1  block holds a valid payload for the downstream stage.
- out_ready  input  1  downstream stage accepts out_data this cycle.
- out_data  output  PAYLOAD_W  held payload.
- stall_cnt  output  STALL_CNT_W  count of cycles with out_valid=1 and out_ready=0.

Behaviour:
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Priority each cycle: reset > flush > normal operation.
- Reset (sampled at a clock edge):
  - out_valid=0, out_data=0, stall_cnt=0, skid entry empty and zeroed.
  - in_ready=0 combinationally while reset is high.
  - Reset asserted mid-transfer discards all held data; no partial state survives.
- Flush (reset low):
  - At the next edge, out_valid=0, out_data=0 (an all-zero payload is the NOP bubble), skid cleared.
  - in_ready=0 combinationally during the flush cycle, so an upstream payload offered in that cycle is never accepted.
  - stall_cnt is not cleared by flush but still counts the flush cycle if out_valid=1 and out_ready=0 in it.
- Main register:
  - Latency from in_fire to out_valid is exactly 1 cycle.
  - Payload is captured bit-exact; no transformation.
- When out_valid drops through out_fire without a refill, out_data holds its last value. Only reset and flush zero it.
- Simultaneous out_fire and in_fire on a full stage: the new payload replaces the old one at the edge, out_valid stays 1, and there is no bubble.
- stall_cnt:
  - +1 on each edge where reset=0, out_valid=1 and out_ready=0.
  - Saturates at 2^STALL_CNT_W-1; no wrap-around.
- Non-skid build (PIPE_SKID_EN undefined):
  - in_ready = ~reset & ~flush & (~out_valid | out_ready).
  - On in_fire: out_data<=in_data, out_valid<=1.
  - Else on out_fire: out_valid<=0.
  - Sustains 1 payload/cycle with out_ready held high.
- The stage never drops or duplicates a payload. Any payload accepted on in_fire appears on out_data exactly once unless reset or flush kills it.

Optional Feature:
- Macro: PIPE_SKID_EN.
- Defined: adds one skid entry (skid_valid, skid_data). in_ready = ~reset & ~flush & ~skid_valid, registered state only, with no combinational path from out_ready. Per edge (normal operation):
  - Main register empty, or out_fire: the main register loads skid_data if skid_valid (clearing skid), else in_data if in_fire, else out_valid<=0.
  - Main register full, no out_fire, and in_fire: in_data goes to skid, skid_valid<=1.
  - in_fire while skid_valid=1 cannot occur (in_ready=0).
  - Ordering is strictly FIFO: the skid payload always exits before a later input.
  - Peak occupancy is 2; latency stays 1 cycle when the skid is empty.
- Undefined: no skid storage. in_ready is combinational from out_ready as described under Behaviour.

Test Plan:
- Reset, then in_valid=1, in_data=0x…A5A5, out_ready=1 -> out_valid=1 and out_data=0x…A5A5 one cycle later; stall_cnt=0.
- Stream 8 payloads 1..8 back-to-back with out_ready=1 -> outputs 1..8 on consecutive cycles with no bubble and in_ready continuously 1.
- Hold out_ready=0 for 5 cycles with a stage full -> out_data stable, stall_cnt=5. Skid build: exactly one more payload accepted, then in_ready=0. Release -> both payloads emerge in order.
- With STALL_CNT_W=4, hold out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt saturates at 15.
- Flush with main full (and skid full when PIPE_SKID_EN) and in_valid=1 -> next cycle out_valid=0, out_data=0, and the flush-cycle input is not delivered.
- Assert reset mid-stream with in_valid=1 -> in_ready=0 during reset; all state zero after; the first post-reset input is delivered normally after 1 cycle.
